// File: rtl/pio_read_arbiter.sv
// pio_read_arbiter: two-requester round-robin read arbiter in front of a PIO
// slave with 1-cycle registered read latency. One transaction at a time:
// IDLE (arbitrate) -> ISSUE (address out, accept) -> CAPTURE (data in).
// Optional feature macro: PIO_CHANGE_IRQ_EN adds a background poller of
// address 0 that raises a sticky irq when the low IN_W input bits change.
module pio_read_arbiter #(
  parameter int IN_W     = 10,
  parameter int POLL_DIV = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic [1:0]  m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic [1:0]  m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata
`ifdef PIO_CHANGE_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       last_grant;   // requester granted most recently (1 after reset)
  logic       grant_sel;    // requester owning the current transaction
  logic       grant_poll;   // current transaction is a background poll
  logic       take_req;
  logic       take_poll;
  logic       next_sel;
  logic [1:0] next_addr;
  logic       poll_req;

  // Arbitration and next-state decode; requesters always beat the poller.
  always_comb begin
    next_state = state;
    take_req   = 1'b0;
    take_poll  = 1'b0;
    next_sel   = last_grant;
    next_addr  = 2'b00;
    case (state)
      IDLE: begin
        if (m0_read || m1_read) begin
          take_req   = 1'b1;
          next_state = ISSUE;
          if (m0_read && m1_read) begin
            next_sel = ~last_grant;
          end else begin
            next_sel = m1_read;
          end
          next_addr = next_sel ? m1_address : m0_address;
        end else if (poll_req) begin
          take_poll  = 1'b1;
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus registered requester-facing and PIO-facing outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      grant_sel        <= 1'b0;
      grant_poll       <= 1'b0;
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= 32'h0000_0000;
      m1_readdata      <= 32'h0000_0000;
      pio_address      <= 2'b00;
    end else begin
      state          <= next_state;
      // Waitrequest drops only for the ISSUE cycle that follows the grant.
      m0_waitrequest <= ~(take_req && (next_sel == 1'b0));
      m1_waitrequest <= ~(take_req && (next_sel == 1'b1));
      // Polls read address 0, which is also the idle value.
      pio_address    <= take_req ? next_addr : 2'b00;
      if (take_req) begin
        grant_sel  <= next_sel;
        last_grant <= next_sel;
      end
      if (take_req || take_poll) begin
        grant_poll <= take_poll;
      end
      m0_readdatavalid <= (state == CAPTURE) && !grant_poll && (grant_sel == 1'b0);
      m1_readdatavalid <= (state == CAPTURE) && !grant_poll && (grant_sel == 1'b1);
      if ((state == CAPTURE) && !grant_poll && (grant_sel == 1'b0)) begin
        m0_readdata <= pio_readdata;
      end
      if ((state == CAPTURE) && !grant_poll && (grant_sel == 1'b1)) begin
        m1_readdata <= pio_readdata;
      end
    end
  end

`ifdef PIO_CHANGE_IRQ_EN
  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  logic [CNT_W-1:0] poll_cnt;
  logic             poll_pending;
  logic [IN_W-1:0]  snapshot;
  logic             poll_done;
  logic             change;

  assign poll_req  = poll_pending;
  assign poll_done = (state == CAPTURE) && grant_poll;
  assign change    = poll_done && (pio_readdata[IN_W-1:0] != snapshot);

  // Poll timer, change detector and sticky irq (set wins over clear).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
      snapshot     <= '0;
      irq          <= 1'b0;
    end else begin
      if (poll_cnt == CNT_W'(POLL_DIV - 1)) begin
        poll_cnt     <= '0;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt + CNT_W'(1);
        if (take_poll) begin
          poll_pending <= 1'b0;
        end else begin
          poll_pending <= poll_pending;
        end
      end
      if (change) begin
        snapshot <= pio_readdata[IN_W-1:0];
      end
      irq <= change | (irq & ~irq_clr);
    end
  end
`else
  // Without the poller the configuration parameters still elaborate here.
  logic [IN_W-1:0] unused_in_bits;
  logic [31:0]     unused_poll_div;

  assign poll_req        = 1'b0;
  assign unused_in_bits  = pio_readdata[IN_W-1:0];
  assign unused_poll_div = 32'(POLL_DIV);
`endif

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Self-checking bench for pio_read_arbiter: per-cycle vector table, directed
// reset-abort sequence, and randomized traffic against a transaction model.
`timescale 1ns/1ps
module tb_pio_read_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_read = 1'b0, m1_read = 1'b0;
  logic [1:0]  m0_address = 2'd0, m1_address = 2'd0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata = 32'd0;
`ifdef PIO_CHANGE_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  logic [31:0] regs [4];
  int tests = 0;
  int fails = 0;

  localparam logic [31:0] D0 = 32'h0000_02A5;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h0000_2222;
  localparam logic [31:0] D3 = 32'hDEAD_BEEF;

  pio_read_arbiter #(.IN_W(10), .POLL_DIV(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .pio_address(pio_address), .pio_readdata(pio_readdata)
`ifdef PIO_CHANGE_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // PIO slave: registered read data, one cycle behind the address.
  always @(posedge clk) pio_readdata <= regs[pio_address];

  // Packed view: {w0, w1, v0, v1, addr[1:0], d0[31:0], d1[31:0]}
  function automatic logic [69:0] pack(input logic w0, input logic w1, input logic v0,
                                       input logic v1, input logic [1:0] a,
                                       input logic [31:0] d0, input logic [31:0] d1);
    return {w0, w1, v0, v1, a, d0, d1};
  endfunction

  localparam logic [69:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0};

  task automatic check(input string name, input logic [69:0] exp);
    logic [69:0] got;
    got = pack(m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
               pio_address, m0_readdata, m1_readdata);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got w0=%b w1=%b v0=%b v1=%b addr=%0d d0=%h d1=%h, expected w0=%b w1=%b v0=%b v1=%b addr=%0d d0=%h d1=%h",
               name, got[69], got[68], got[67], got[66], got[65:64], got[63:32], got[31:0],
               exp[69], exp[68], exp[67], exp[66], exp[65:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic drive(input logic r0, input logic [1:0] a0, input logic r1, input logic [1:0] a1);
    m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
  endtask

  // Wait for the active edge, then sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // A read accepted at edge k shows waitrequest low after edge k, data valid
  // after edge k+2, and the arbiter may accept again from edge k+3 on.
  int          ecnt = 0;
  int          m_next_ok = 0;
  int          m_acc = 0;
  bit          m_busy = 0;
  bit          m_last = 1;
  bit          m_g = 0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_d0 = 32'd0, m_d1 = 32'd0;
  logic        m_w0 = 1, m_w1 = 1, m_v0 = 0, m_v1 = 0;
  logic [1:0]  m_addr = 2'd0;

  task automatic model_step();
    bit g;
    logic [1:0] a;
    ecnt++;
    m_w0 = 1; m_w1 = 1; m_v0 = 0; m_v1 = 0; m_addr = 2'd0;
    if (!reset_n) begin
      m_last = 1; m_busy = 0; m_d0 = 32'd0; m_d1 = 32'd0;
      m_next_ok = ecnt + 1;
      return;
    end
    if (m_busy && ecnt == m_acc + 2) begin
      m_busy = 0;
      if (m_g) begin m_v1 = 1; m_d1 = m_data; end
      else     begin m_v0 = 1; m_d0 = m_data; end
    end
    if (!m_busy && ecnt >= m_next_ok && (m0_read || m1_read)) begin
      g = (m0_read && m1_read) ? !m_last : m1_read;
      a = g ? m1_address : m0_address;
      m_last = g; m_g = g; m_acc = ecnt; m_busy = 1; m_next_ok = ecnt + 3;
      m_data = regs[a]; m_addr = a;
      if (g) m_w1 = 0; else m_w0 = 0;
    end
  endtask

  typedef struct {
    logic        r0;
    logic [1:0]  a0;
    logic        r1;
    logic [1:0]  a1;
    logic [69:0] exp;
  } vec_t;

  vec_t vt [20];

  initial begin
    regs[0] = D0; regs[1] = D1; regs[2] = D2; regs[3] = D3;
    reset_n = 1'b0;
    step(); step();
    check("reset_state", RST_OUT);
`ifdef PIO_CHANGE_IRQ_EN
    begin
      int bad;
      int waited;
      bit seen;
      regs[0] = 32'h0000_0001;
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL irq_reset: got %b expected 0", irq); end
      reset_n = 1'b1;
      // Continuous m0 reads: poll can never be taken, irq must stay low.
      drive(1'b1, 2'd1, 1'b0, 2'd0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin step(); if (irq !== 1'b0) bad++; end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL irq_busy: got %0d cycles with irq high, expected 0", bad); end
      // Idle: change 0x000 -> 0x001 must set irq within two poll periods.
      drive(1'b0, 2'd0, 1'b0, 2'd0);
      seen = 0; bad = 0; waited = 0;
      for (int i = 0; i < 2 * 16 + 6 && !seen; i++) begin
        step(); waited++;
        if (m0_readdatavalid || m1_readdatavalid) bad++;
        if (irq === 1'b1) seen = 1;
      end
      tests++;
      if (!seen) begin fails++; $display("FAIL irq_set: irq not set after %0d cycles, expected 1", waited); end
      tests++;
      if (bad > 1) begin fails++; $display("FAIL poll_valid: got %0d readdatavalid pulses, expected at most the trailing m0 one", bad); end
      irq_clr = 1'b1; step(); irq_clr = 1'b0;
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr: got %b expected 0", irq); end
      bad = 0;
      for (int i = 0; i < 40; i++) begin step(); if (irq !== 1'b0) bad++; end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL irq_stable: got %0d cycles with irq high, expected 0", bad); end
    end
`else
    // -------- vector table: contention from reset, m1 addr 3, m0 read --------
    for (int i = 0; i < 11; i++) begin vt[i].r0 = 1; vt[i].a0 = 2'd1; vt[i].r1 = 1; vt[i].a1 = 2'd2; end
    for (int i = 11; i < 20; i++) begin vt[i].r0 = 0; vt[i].a0 = 2'd0; vt[i].r1 = 0; vt[i].a1 = 2'd0; end
    vt[13].r1 = 1; vt[13].a1 = 2'd3;
    vt[16].r0 = 1; vt[16].a0 = 2'd0;
    vt[0].exp  = pack(0, 1, 0, 0, 2'd1, 32'd0, 32'd0);
    vt[1].exp  = pack(1, 1, 0, 0, 2'd0, 32'd0, 32'd0);
    vt[2].exp  = pack(1, 1, 1, 0, 2'd0, D1, 32'd0);
    vt[3].exp  = pack(1, 0, 0, 0, 2'd2, D1, 32'd0);
    vt[4].exp  = pack(1, 1, 0, 0, 2'd0, D1, 32'd0);
    vt[5].exp  = pack(1, 1, 0, 1, 2'd0, D1, D2);
    vt[6].exp  = pack(0, 1, 0, 0, 2'd1, D1, D2);
    vt[7].exp  = pack(1, 1, 0, 0, 2'd0, D1, D2);
    vt[8].exp  = pack(1, 1, 1, 0, 2'd0, D1, D2);
    vt[9].exp  = pack(1, 0, 0, 0, 2'd2, D1, D2);
    vt[10].exp = pack(1, 1, 0, 0, 2'd0, D1, D2);
    vt[11].exp = pack(1, 1, 0, 1, 2'd0, D1, D2);
    vt[12].exp = pack(1, 1, 0, 0, 2'd0, D1, D2);
    vt[13].exp = pack(1, 0, 0, 0, 2'd3, D1, D2);
    vt[14].exp = pack(1, 1, 0, 0, 2'd0, D1, D2);
    vt[15].exp = pack(1, 1, 0, 1, 2'd0, D1, D3);
    vt[16].exp = pack(0, 1, 0, 0, 2'd0, D1, D3);
    vt[17].exp = pack(1, 1, 0, 0, 2'd0, D1, D3);
    vt[18].exp = pack(1, 1, 1, 0, 2'd0, D0, D3);
    vt[19].exp = pack(1, 1, 0, 0, 2'd0, D0, D3);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].r0, vt[i].a0, vt[i].r1, vt[i].a1);
      step();
      check($sformatf("vec%0d", i), vt[i].exp);
    end

    // -------- reset during CAPTURE aborts the read --------
    drive(1'b1, 2'd3, 1'b0, 2'd0); step();
    check("abort_issue", pack(0, 1, 0, 0, 2'd3, D0, D3));
    drive(1'b0, 2'd0, 1'b0, 2'd0); step();
    check("abort_capture", pack(1, 1, 0, 0, 2'd0, D0, D3));
    reset_n = 1'b0; step();
    check("abort_reset", RST_OUT);
    reset_n = 1'b1; step();
    check("abort_no_valid", RST_OUT);
    // Pointer back to reset value: m0 wins contention again.
    drive(1'b1, 2'd2, 1'b1, 2'd1); step();
    check("rr_after_reset", pack(0, 1, 0, 0, 2'd2, 32'd0, 32'd0));
    drive(1'b0, 2'd0, 1'b0, 2'd0); step(); step();
    check("rr_after_reset_data", pack(1, 1, 1, 0, 2'd0, D2, 32'd0));

    // -------- randomized traffic against the model --------
    for (int i = 0; i < 4; i++) regs[i] = $urandom;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin @(posedge clk); model_step(); #1; end
    reset_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)));
      reset_n = ($urandom_range(0, 59) != 0);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("rand%0d", i), pack(m_w0, m_w1, m_v0, m_v1, m_addr, m_d0, m_d1));
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
